// File: rtl/rx_stream_sink.sv
// rx_stream_sink
// Receiving end of a valid/ready word stream. Incoming words are buffered in a
// DEPTH-entry FIFO and presented first-word-fall-through to a downstream
// consumer. The sink backpressures the transmitter through ready when the FIFO
// is full.
//
// Optional feature: define RX_SEQ_CHECK_EN to build an in-line sequence checker.
// The checker flags any accepted word that is not the previous word + 1.
// Without the macro, seq_err and err_count are tied to zero.
//
// Ports
//   clk        single clock, all logic on posedge
//   rst        synchronous active-high reset
//   data       stream data from the transmitter
//   valid      transmitter has a word on data
//   ready      sink can accept (transfer = valid & ready at posedge)
//   out_data   head-of-FIFO word (don't-care while out_valid = 0)
//   out_valid  FIFO non-empty
//   out_ready  consumer pops (pop = out_valid & out_ready at posedge)
//   level      current occupancy 0..DEPTH
//   rx_count   words accepted since reset, wraps at 2^32
//   seq_err    sticky sequence error flag
//   err_count  saturating count of sequence errors
module rx_stream_sink #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  level,
    output logic [31:0]       rx_count,
    output logic              seq_err,
    output logic [15:0]       err_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [31:0]      rx_count_q, rx_count_d;

    logic push;
    logic pop;

    // ready and out_valid come from registered state only (plus rst), so
    // there is no combinational path from valid or out_ready. A full FIFO
    // refuses a word even when a pop happens in the same cycle.
    assign ready     = !rst && (level_q != LVL_W'(DEPTH));
    assign out_valid = !rst && (level_q != '0);
    assign push      = valid && ready;
    assign pop       = out_valid && out_ready;

    assign out_data  = mem[rd_ptr_q];
    assign level     = level_q;
    assign rx_count  = rx_count_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rx_count_d = rx_count_q;
        if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            rx_count_d = rx_count_q + 32'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rx_count_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rx_count_q <= rx_count_d;
        end
    end

    // Storage is not reset. push is already gated by rst through ready.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= data;
        end
    end

`ifdef RX_SEQ_CHECK_EN
    logic              primed_q, primed_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              seq_err_q, seq_err_d;
    logic [15:0]       err_count_q, err_count_d;

    always_comb begin
        primed_d    = primed_q;
        exp_d       = exp_q;
        seq_err_d   = seq_err_q;
        err_count_d = err_count_q;
        if (push) begin
            // Always resync to the word just seen. The first word after
            // reset only primes the expectation.
            primed_d = 1'b1;
            exp_d    = data + DATA_W'(1);
            if (primed_q && (data != exp_q)) begin
                seq_err_d = 1'b1;
                if (err_count_q != 16'hFFFF) begin
                    err_count_d = err_count_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            primed_q    <= 1'b0;
            exp_q       <= '0;
            seq_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            primed_q    <= primed_d;
            exp_q       <= exp_d;
            seq_err_q   <= seq_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign seq_err   = seq_err_q;
    assign err_count = err_count_q;
`else
    assign seq_err   = 1'b0;
    assign err_count = 16'd0;
`endif

endmodule
